fetch_decode_stage: RTL and testbench

- Front end of the pipelined CPU: the IF and ID stages feeding the datapath.
- Holds the PC and issues the instruction-memory address. Registers the fetched word into the IF/ID register.
- Decodes the opcode into the WBID/MEID/EXID control lines and the instr bus that the datapath consumes.
- Contains load-use hazard detection (stall + bubble) and taken-branch flush.

---
 rtl/fetch_decode_stage.sv | 129 ++++++++++++
 tb/tb_fetch_decode_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// IF/ID front end: PC and fetch, IF/ID register, opcode decode into control
// lines, load-use stall with bubble insertion and taken-branch flush.
module fetch_decode_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic [31:0]      instr,
  output logic [PC_W-1:0]  pc_id,
  output logic [1:0]       WBID,
  output logic [2:0]       MEID,
  output logic [3:0]       EXID,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [PC_W-1:0]  r_pc;
  logic [31:0]      r_instr;
  logic [PC_W-1:0]  r_pc_id;
  logic [CNT_W-1:0] r_stall_count;

  logic [5:0]       w_opcode;
  logic [1:0]       w_wb;
  logic [2:0]       w_me;
  logic [3:0]       w_ex;
  logic             w_uses_rt;
  logic             w_stall;
  logic [PC_W-1:0]  w_pc_plus4;

  assign w_opcode   = r_instr[31:26];
  assign w_pc_plus4 = r_pc + PC_W'(4);

  // Opcode decode; the all-zero word is a NOP even though it shares the R-type opcode.
  always_comb begin
    w_wb      = 2'b00;
    w_me      = 3'b000;
    w_ex      = 4'b0000;
    w_uses_rt = 1'b0;
    if (r_instr == 32'h0000_0000) begin
      w_uses_rt = 1'b0;
    end else begin
      case (w_opcode)
        OP_RTYPE: begin w_wb = 2'b11; w_ex = 4'b0100; w_uses_rt = 1'b1; end
        OP_LW:    begin w_wb = 2'b10; w_me = 3'b010; w_ex = 4'b1001; end
        OP_SW:    begin w_me = 3'b001; w_ex = 4'b0001; w_uses_rt = 1'b1; end
        OP_BEQ:   begin w_me = 3'b100; w_ex = 4'b0010; w_uses_rt = 1'b1; end
        OP_ADDI:  begin w_wb = 2'b11; w_ex = 4'b1001; end
        default:  begin w_wb = 2'b00; w_me = 3'b000; w_ex = 4'b0000; end
      endcase
    end
  end

  // Load-use hazard: a pending load whose destination feeds a source of the ID instruction.
  always_comb begin
    w_stall = 1'b0;
    if (ex_mem_read && (ex_rt != 5'd0)) begin
      w_stall = (ex_rt == r_instr[25:21]) || (w_uses_rt && (ex_rt == r_instr[20:16]));
    end else begin
      w_stall = 1'b0;
    end
  end

  // Control outputs, zeroed during a stall to push a bubble into ID/EX.
  always_comb begin
    WBID = 2'b00;
    MEID = 3'b000;
    EXID = 4'b0000;
    if (w_stall) begin
      WBID = 2'b00;
    end else begin
      WBID = w_wb;
      MEID = w_me;
      EXID = w_ex;
    end
  end

  // PC and IF/ID register: flush beats stall, stall beats normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0000;
      r_pc_id <= {PC_W{1'b0}};
    end else if (branch_taken) begin
      r_pc    <= branch_target;
      r_instr <= 32'h0000_0000;
      r_pc_id <= {PC_W{1'b0}};
    end else if (!w_stall) begin
      r_pc    <= w_pc_plus4;
      r_instr <= imem_data;
      r_pc_id <= w_pc_plus4;
    end else begin
      r_pc    <= r_pc;
      r_instr <= r_instr;
      r_pc_id <= r_pc_id;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign pc_id       = r_pc_id;
  assign stall       = w_stall;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Randomized and directed bench for fetch_decode_stage against a behavioural
// front-end model (instruction table lookup, hazard rule, saturating counter).
module tb_fetch_decode_stage;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [PC_W-1:0]  imem_addr;
  logic [31:0]      imem_data;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic [31:0]      instr;
  logic [PC_W-1:0]  pc_id;
  logic [1:0]       WBID;
  logic [2:0]       MEID;
  logic [3:0]       EXID;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  logic [31:0] mem [0:63];

  int n_vec;
  int n_err;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc_id;
  int          m_cnt;

  fetch_decode_stage #(.PC_W(PC_W), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .instr(instr), .pc_id(pc_id),
    .WBID(WBID), .MEID(MEID), .EXID(EXID), .stall(stall), .stall_count(stall_count)
  );

  assign imem_data = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control bundle {WB,ME,EX} from the instruction table.
  function automatic logic [8:0] ref_ctrl(input logic [31:0] w);
    if (w == 32'h0) return 9'b0;
    case (w[31:26])
      6'b000000: return 9'b11_000_0100;
      6'b100011: return 9'b10_010_1001;
      6'b101011: return 9'b00_001_0001;
      6'b000100: return 9'b00_100_0010;
      6'b001000: return 9'b11_000_1001;
      default:   return 9'b0;
    endcase
  endfunction

  function automatic bit ref_stall(input logic [31:0] w, input bit rd, input logic [4:0] rt);
    bit rt_src;
    rt_src = (w != 32'h0) && (w[31:26] == 6'b000000 || w[31:26] == 6'b101011 || w[31:26] == 6'b000100);
    if (!rd || rt == 5'd0) return 1'b0;
    return (rt == w[25:21]) || (rt_src && rt == w[20:16]);
  endfunction

  task automatic check_all();
    bit st;
    st = ref_stall(m_instr, ex_mem_read, ex_rt);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr", instr, m_instr);
    chk("pc_id", pc_id, m_pc_id);
    chk("stall", {31'b0, stall}, {31'b0, st});
    chk("ctrl", {23'b0, WBID, MEID, EXID}, {23'b0, (st ? 9'b0 : ref_ctrl(m_instr))});
    chk("stall_count", {28'b0, stall_count}, m_cnt);
  endtask

  task automatic step(input bit r, input bit rd, input logic [4:0] rt,
                      input bit bt, input logic [31:0] tgt, input bit do_chk);
    bit st;
    rst = r; ex_mem_read = rd; ex_rt = rt; branch_taken = bt; branch_target = tgt;
    #1;
    if (do_chk) check_all();
    @(posedge clk);
    st = ref_stall(m_instr, rd, rt);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc_id = 32'h0; m_cnt = 0;
    end else begin
      if (st && m_cnt < 15) m_cnt++;
      if (bt) begin
        m_pc = tgt; m_instr = 32'h0; m_pc_id = 32'h0;
      end else if (!st) begin
        m_instr = mem[m_pc[7:2]]; m_pc = m_pc + 32'd4; m_pc_id = m_pc;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [5:0] ops [0:5];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b111111;
    if ($urandom_range(0, 9) == 0) return 32'h0;
    return {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            16'($urandom)};
  endfunction

  logic [8:0] exp_dec [0:5];

  initial begin
    n_vec = 0; n_err = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc_id = 32'h0; m_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h8C220004; mem[1] = 32'hAC220004; mem[2] = 32'h10220003;
    mem[3] = 32'h20220005; mem[4] = 32'h00221820; mem[5] = 32'hFC000000;
    mem[6] = 32'h00221820; mem[7] = 32'h20220005; mem[16] = 32'h00221820;
    exp_dec[0] = 9'b10_010_1001; exp_dec[1] = 9'b00_001_0001; exp_dec[2] = 9'b00_100_0010;
    exp_dec[3] = 9'b11_000_1001; exp_dec[4] = 9'b11_000_0100; exp_dec[5] = 9'b0;

    // reset and sequential fetch with decode of each table entry
    step(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    chk("reset_pc", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
      chk("fetch_addr", imem_addr, 32'(4 * (i + 1)));
      chk("decode", {23'b0, WBID, MEID, EXID}, {23'b0, exp_dec[i]});
      if (i == 0) chk("pc_id_first", pc_id, 32'h4);
    end

    // load-use against add, then release
    step(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 5'd2, 1'b0, 32'h0, 1'b1);
    chk("lu_pc_hold", imem_addr, 32'd28);
    chk("lu_instr_hold", instr, 32'h00221820);
    chk("lu_count", {28'b0, stall_count}, 32'd1);
    chk("lu_stall", {31'b0, stall}, 32'd1);
    chk("lu_bubble", {23'b0, WBID, MEID, EXID}, 32'd0);
    step(1'b0, 1'b0, 5'd2, 1'b0, 32'h0, 1'b1);
    chk("lu_resume", instr, 32'h20220005);

    // addi reads only rs=1: a load to r2 must not stall it
    ex_mem_read = 1'b1; ex_rt = 5'd2; #1;
    chk("no_false_stall", {31'b0, stall}, 32'd0);

    // flush concurrent with a stall
    step(1'b0, 1'b1, 5'd1, 1'b1, 32'h40, 1'b1);
    chk("br_pc", imem_addr, 32'h40);
    chk("br_instr", instr, 32'h0);
    chk("br_pc_id", pc_id, 32'h0);

    // saturation
    step(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 5'd2, 1'b0, 32'h0, 1'b1);
    chk("sat_count", {28'b0, stall_count}, 32'd15);
    step(1'b1, 1'b1, 5'd2, 1'b0, 32'h0, 1'b1);
    chk("sat_rst", {28'b0, stall_count}, 32'd0);

    // random traffic
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           {24'b0, 6'($urandom), 2'b00}, 1'b1);
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
